// File: rtl/acc_ctrl_cfg_seq.sv
// acc_ctrl_cfg_seq: AXI4-Lite master that writes config words, launches acc_ctrl
// and polls its status register until done or a poll limit is reached.
module acc_ctrl_cfg_seq #(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_DATA_WIDTH = 32,
    parameter logic [C_ADDR_WIDTH-1:0] BASE_ADDR = 32'h4000_0000,
    parameter int NUM_CFG = 4,
    parameter logic [C_ADDR_WIDTH-1:0] CTRL_OFF = 32'h20,
    parameter logic [C_ADDR_WIDTH-1:0] STAT_OFF = 32'h24,
    parameter int POLL_GAP = 16,
    parameter int POLL_MAX = 1024
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      start,
    input  logic [NUM_CFG*32-1:0]     cfg_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [1:0]                err_code,
    output logic [C_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [C_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [C_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [C_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);
    localparam int IW = NUM_CFG > 1 ? $clog2(NUM_CFG) : 1;
    localparam int PW = $clog2(POLL_MAX + 1);
    localparam int GW = POLL_GAP > 1 ? $clog2(POLL_GAP) : 1;

    typedef enum logic [2:0] {IDLE, WR, WRESP, GAP, RADDR, RDATA, DONE, ERR} state_t;

    state_t            state, nxt;
    logic [31:0]       cfg_w [NUM_CFG];
    logic [31:0]       cfg_q [NUM_CFG];
    logic [IW-1:0]     idx, nidx;
    logic              ctrl_ph, last_cfg, last_poll, wr_fin, unused_rdata;
    logic [PW-1:0]     poll_cnt;
    logic [GW-1:0]     gap_cnt;

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg
        assign cfg_w[g] = cfg_data[32*g +: 32];
    end

    assign nidx          = idx + 1'b1;
    assign last_cfg      = idx == IW'(NUM_CFG - 1);
    assign last_poll     = poll_cnt == PW'(POLL_MAX - 1);
    assign wr_fin        = (!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready);
    assign unused_rdata  = ^m_axi_rdata[C_DATA_WIDTH-1:1];
    assign m_axi_awprot  = '0;
    assign m_axi_arprot  = '0;
    assign m_axi_wstrb   = '1;
    assign m_axi_bready  = state == WRESP;
    assign m_axi_rready  = state == RDATA;
    assign m_axi_arvalid = state == RADDR;
    assign m_axi_araddr  = m_axi_arvalid ? BASE_ADDR + STAT_OFF : '0;
    assign busy          = !(state inside {IDLE, DONE, ERR});
    assign done          = state == DONE;
    assign err           = state == ERR;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? WR : IDLE;
            WR:      nxt = wr_fin ? WRESP : WR;
            WRESP:   nxt = !m_axi_bvalid ? WRESP : m_axi_bresp != 2'b00 ? ERR : ctrl_ph ? GAP : WR;
            GAP:     nxt = gap_cnt == GW'(POLL_GAP - 1) ? RADDR : GAP;
            RADDR:   nxt = m_axi_arready ? RDATA : RADDR;
            RDATA:   nxt = !m_axi_rvalid ? RDATA : m_axi_rresp != 2'b00 ? ERR :
                           m_axi_rdata[0] ? DONE : last_poll ? ERR : GAP;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state         <= IDLE;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_wdata   <= '0;
            err_code      <= '0;
            idx           <= '0;
            ctrl_ph       <= 1'b0;
            poll_cnt      <= '0;
            gap_cnt       <= '0;
            cfg_q         <= '{default: '0};
        end else begin
            state   <= nxt;
            gap_cnt <= (state == GAP && nxt == GAP) ? gap_cnt + 1'b1 : '0;
            if (state == IDLE && start) begin
                cfg_q         <= cfg_w;
                err_code      <= '0;
                idx           <= '0;
                ctrl_ph       <= 1'b0;
                m_axi_awvalid <= 1'b1;
                m_axi_wvalid  <= 1'b1;
                m_axi_awaddr  <= BASE_ADDR;
                m_axi_wdata   <= C_DATA_WIDTH'(cfg_w[0]);
            end
            if (state == WR) begin
                m_axi_awvalid <= m_axi_awvalid & ~m_axi_awready;
                m_axi_wvalid  <= m_axi_wvalid & ~m_axi_wready;
            end
            if (state == WRESP && m_axi_bvalid) begin
                if (m_axi_bresp != 2'b00) begin
                    err_code <= 2'b01;
                end else if (!ctrl_ph) begin
                    // After the last config word the same write path carries the start bit
                    m_axi_awvalid <= 1'b1;
                    m_axi_wvalid  <= 1'b1;
                    ctrl_ph       <= last_cfg;
                    idx           <= nidx;
                    m_axi_awaddr  <= last_cfg ? BASE_ADDR + CTRL_OFF : BASE_ADDR + C_ADDR_WIDTH'(4 * nidx);
                    m_axi_wdata   <= last_cfg ? C_DATA_WIDTH'(1) : C_DATA_WIDTH'(cfg_q[nidx]);
                end else begin
                    poll_cnt <= '0;
                end
            end
            if (state == RDATA && m_axi_rvalid) begin
                if (m_axi_rresp != 2'b00) begin
                    err_code <= 2'b10;
                end else if (!m_axi_rdata[0]) begin
                    poll_cnt <= poll_cnt + 1'b1;
                    if (last_poll)
                        err_code <= 2'b11;
                end
            end
        end
    end
endmodule

// File: tb/tb_acc_ctrl_cfg_seq.sv
// tb_acc_ctrl_cfg_seq: directed vectors against a configurable AXI4-Lite slave model
// for acc_ctrl_cfg_seq, plus hand sequences for reset and start-ignore corners.
module tb_acc_ctrl_cfg_seq;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic         tb_ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic         start = 1'b0;
    logic [127:0] cfg_data = '0;
    logic         busy, done, err;
    logic [1:0]   err_code;
    logic [31:0]  awaddr, wdata, araddr, rdata;
    logic [2:0]   awprot, arprot;
    logic [3:0]   wstrb;
    logic         awvalid, wvalid, bready, arvalid, rready;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;

    always #5 tb_ACLK = ~tb_ACLK;

    acc_ctrl_cfg_seq #(.POLL_MAX(8)) dut (
        .ACLK(tb_ACLK), .ARESETN(ARESETN), .start(start), .cfg_data(cfg_data),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    // Slave behaviour knobs, set by the stimulus before each run
    int aw_dly = 0, w_dly = 0, berr_at = -1, polls0 = 0;
    bit alt = 0, rerr = 0, clr = 0;
    int ad, wd;
    int naw, nw, nb, nrd, stab, idle, min_idle;
    bit aw_got, w_got, rd_seen, pa, pw, par, par_prev;
    int aw_wait, w_wait;
    logic [31:0] aw_log [16];
    logic [31:0] w_log [16];
    logic [31:0] pa_addr, pw_data, par_addr;

    assign ad = (alt && nb[0]) ? w_dly : aw_dly;
    assign wd = (alt && nb[0]) ? aw_dly : w_dly;

    always @(posedge tb_ACLK) begin
        if (!ARESETN) begin
            awready <= 0; wready <= 0; bvalid <= 0; bresp <= 0;
            arready <= 0; rvalid <= 0; rdata <= 0; rresp <= 0;
            aw_got <= 0; w_got <= 0; aw_wait <= 0; w_wait <= 0;
            pa <= 0; pw <= 0; par <= 0; par_prev <= 0;
        end else begin
            if (awvalid && awready) begin
                if (naw < 16) aw_log[naw] <= awaddr;
                naw <= naw + 1; aw_got <= 1; awready <= (ad == 0); aw_wait <= 0;
            end else if (ad == 0) awready <= 1;
            else if (awvalid && !aw_got) begin
                if (aw_wait + 1 >= ad) awready <= 1;
                aw_wait <= aw_wait + 1;
            end
            if (wvalid && wready) begin
                if (nw < 16) w_log[nw] <= wdata;
                nw <= nw + 1; w_got <= 1; wready <= (wd == 0); w_wait <= 0;
            end else if (wd == 0) wready <= 1;
            else if (wvalid && !w_got) begin
                if (w_wait + 1 >= wd) wready <= 1;
                w_wait <= w_wait + 1;
            end
            if (aw_got && w_got && !bvalid) begin
                bvalid <= 1; bresp <= (nb == berr_at) ? 2'b10 : 2'b00;
                nb <= nb + 1; aw_got <= 0; w_got <= 0;
            end else if (bvalid && bready) bvalid <= 0;
            if (arvalid && arready) begin
                arready <= 0; rvalid <= 1; nrd <= nrd + 1;
                rdata <= (nrd < polls0) ? 32'hFFFF_FFFE : 32'h0000_0001;
                rresp <= (rerr && nrd == 0) ? 2'b11 : 2'b00;
                rd_seen <= 1; idle <= 0;
            end else begin
                if (arvalid && !rvalid) arready <= 1;
                if (rvalid && rready) rvalid <= 0;
                if (!arvalid) idle <= idle + 1;
            end
            if (arvalid && !par_prev && rd_seen && idle < min_idle) min_idle <= idle;
            par_prev <= arvalid;
            if ((pa && (!awvalid || awaddr != pa_addr)) || (pw && (!wvalid || wdata != pw_data)) ||
                (par && (!arvalid || araddr != par_addr))) stab <= stab + 1;
            pa <= awvalid && !awready; pa_addr <= awaddr;
            pw <= wvalid && !wready;   pw_data <= wdata;
            par <= arvalid && !arready; par_addr <= araddr;
        end
        if (clr) begin
            naw <= 0; nw <= 0; nb <= 0; nrd <= 0; stab <= 0;
            rd_seen <= 0; idle <= 0; min_idle <= 9999;
        end
    end

    typedef struct {
        logic [127:0] cfg;
        int aw_dly; int w_dly; bit alt; int berr_at; int polls0; bit rerr;
        bit exp_done; logic [1:0] exp_code; int exp_wr; int exp_rd;
    } vec_t;

    vec_t vecs [8];
    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_slave(input vec_t v);
        aw_dly = v.aw_dly; w_dly = v.w_dly; alt = v.alt;
        berr_at = v.berr_at; polls0 = v.polls0; rerr = v.rerr;
        clr = 1;
        @(negedge tb_ACLK);
        clr = 0;
    endtask

    task automatic wait_end(input string tag, output bit ok, output int blow);
        int n = 0;
        blow = 0;
        while (!(done || err) && n < 3000) begin
            if (!busy) blow++;
            @(negedge tb_ACLK);
            n++;
        end
        ok = (n < 3000);
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL %s.no_completion: no done/err within %0d cycles", tag, n);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bit ok;
        int blow;
        logic [31:0] ea, ed;
        set_slave(v);
        cfg_data = v.cfg; start = 1;
        @(negedge tb_ACLK);
        start = 0; cfg_data = ~v.cfg;
        chk({tag, ".busy_after_start"}, {31'b0, busy}, 1);
        chk({tag, ".code_cleared"}, {30'b0, err_code}, 0);
        wait_end(tag, ok, blow);
        if (!ok) return;
        chk({tag, ".done"}, {31'b0, done}, {31'b0, v.exp_done});
        chk({tag, ".err"}, {31'b0, err}, {31'b0, !v.exp_done});
        chk({tag, ".busy_at_pulse"}, {31'b0, busy}, 0);
        chk({tag, ".err_code"}, {30'b0, err_code}, {30'b0, v.exp_code});
        chk({tag, ".busy_dropouts"}, blow, 0);
        @(negedge tb_ACLK);
        chk({tag, ".pulse_width"}, {31'b0, done | err}, 0);
        chk({tag, ".err_code_held"}, {30'b0, err_code}, {30'b0, v.exp_code});
        chk({tag, ".aw_count"}, naw, v.exp_wr);
        chk({tag, ".w_count"}, nw, v.exp_wr);
        chk({tag, ".reads"}, nrd, v.exp_rd);
        chk({tag, ".stability"}, stab, 0);
        chk({tag, ".poll_spacing_ok"}, {31'b0, min_idle >= 16}, 1);
        for (int k = 0; k < v.exp_wr && k < naw && k < nw; k++) begin
            ea = k < 4 ? BASE + 32'(4 * k) : BASE + 32'h20;
            ed = k < 4 ? v.cfg[32*k +: 32] : 32'h1;
            chk($sformatf("%s.awaddr%0d", tag, k), aw_log[k], ea);
            chk($sformatf("%s.wdata%0d", tag, k), w_log[k], ed);
        end
    endtask

    initial begin
        bit ok;
        int blow, pulses;
        vecs[0] = '{128'hbeef0011_dead0011_abcd0001_0101FFFF, 0, 0, 1'b0, -1, 0,   1'b0, 1'b1, 2'b00, 5, 1};
        vecs[1] = '{128'h11112222_33334444_55556666_77778888, 4, 1, 1'b1, -1, 0,   1'b0, 1'b1, 2'b00, 5, 1};
        vecs[2] = '{128'hcafe0003_cafe0002_cafe0001_cafe0000, 0, 0, 1'b0,  2, 0,   1'b0, 1'b0, 2'b01, 3, 0};
        vecs[3] = '{128'h00000004_00000003_00000002_00000001, 0, 0, 1'b0, -1, 5,   1'b0, 1'b1, 2'b00, 5, 6};
        vecs[4] = '{128'hA5A5A5A5_5A5A5A5A_FFFFFFFF_00000000, 0, 0, 1'b0, -1, 100, 1'b0, 1'b0, 2'b11, 5, 8};
        vecs[5] = '{128'h12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0, 0, 0, 1'b0, -1, 0,   1'b1, 1'b0, 2'b10, 5, 1};
        vecs[6] = '{128'h87654321_00000000_DEADBEEF_0000FFFF, 2, 0, 1'b0,  4, 0,   1'b0, 1'b0, 2'b01, 5, 0};
        vecs[7] = '{128'h76543210_FEDCBA98_01234567_89ABCDEF, 2, 2, 1'b0, -1, 7,   1'b0, 1'b1, 2'b00, 5, 8};
        repeat (3) @(negedge tb_ACLK);
        chk("reset.busy", {31'b0, busy}, 0);
        chk("reset.done_err", {30'b0, done, err}, 0);
        chk("reset.valids", {29'b0, awvalid, wvalid, arvalid}, 0);
        chk("reset.readies", {30'b0, bready, rready}, 0);
        chk("reset.err_code", {30'b0, err_code}, 0);
        chk("reset.awaddr", awaddr, 0);
        chk("reset.wdata", wdata, 0);
        chk("reset.araddr", araddr, 0);
        chk("const.prot_strb", {22'b0, awprot, arprot, wstrb}, 32'h0000_000F);
        ARESETN = 1;
        @(negedge tb_ACLK);
        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Start while busy and start during the done pulse must both be ignored
        set_slave(vecs[0]);
        cfg_data = vecs[0].cfg; start = 1;
        @(negedge tb_ACLK);
        start = 0;
        repeat (3) @(negedge tb_ACLK);
        start = 1;
        @(negedge tb_ACLK);
        start = 0;
        wait_end("ign", ok, blow);
        if (ok) begin
            chk("ign.done", {31'b0, done}, 1);
            chk("ign.writes_once", naw, 5);
            start = 1;
            @(negedge tb_ACLK);
            start = 0;
            chk("ign.start_on_pulse", {31'b0, busy}, 0);
            start = 1;
            @(negedge tb_ACLK);
            start = 0;
            chk("ign.start_after_pulse", {31'b0, busy}, 1);
            wait_end("ign2", ok, blow);
            chk("ign2.done", {31'b0, done}, 1);
            chk("ign2.writes", naw, 10);
            chk("ign2.reads", nrd, 2);
            @(negedge tb_ACLK);
        end

        // Reset pulse while AW/W are stalled aborts without a completion pulse
        set_slave('{128'h0, 100, 100, 1'b0, -1, 0, 1'b0, 1'b1, 2'b00, 0, 0});
        cfg_data = vecs[0].cfg; start = 1;
        @(negedge tb_ACLK);
        start = 0;
        repeat (4) @(negedge tb_ACLK);
        chk("rst.stalled_awvalid", {31'b0, awvalid}, 1);
        ARESETN = 0;
        @(negedge tb_ACLK);
        ARESETN = 1;
        chk("rst.valids", {29'b0, awvalid, wvalid, arvalid}, 0);
        chk("rst.busy", {31'b0, busy}, 0);
        chk("rst.awaddr", awaddr, 0);
        pulses = 0;
        repeat (20) begin
            @(negedge tb_ACLK);
            pulses += int'(done | err | busy);
        end
        chk("rst.no_completion", pulses, 0);
        run_vec(vecs[0], "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/acc_ctrl_cfg_seq.md
Name: acc_ctrl_cfg_seq

Overview:
AXI4-Lite master sequencer that configures and launches the acc_ctrl accelerator register block without processor involvement. On a start pulse it writes NUM_CFG configuration words to consecutive slave registers and writes the start bit to the control register. It then polls the status register until the done bit is set or a poll limit is reached, and reports completion or error. It sits between the local control logic and the acc_ctrl AXI4-Lite slave port.

Parameters:
C_ADDR_WIDTH, 32, AXI address width
C_DATA_WIDTH, 32, AXI data width (fixed at 32)
BASE_ADDR, 32'h4000_0000, acc_ctrl slave base address
NUM_CFG, 4, config registers written, range 1..8, at BASE_ADDR+4*i
CTRL_OFF, 32'h20, control register offset; bit0=start
STAT_OFF, 32'h24, status register offset; bit0=done
POLL_GAP, 16, idle cycles between status reads, >=1
POLL_MAX, 1024, status reads before timeout

Ports:
ACLK in 1 clock
ARESETN in 1 synchronous active-low reset
start in 1 single-cycle launch request
cfg_data in NUM_CFG*32 config words; word i = bits [32i+31:32i]
busy out 1 sequence in progress
done out 1 one-cycle pulse, success
err out 1 one-cycle pulse, failure
err_code out 2 01=write resp, 10=read resp, 11=timeout; held until next start
m_axi_awaddr/awprot/awvalid/awready out/out/out/in 32/3/1/1 write address channel
m_axi_wdata/wstrb/wvalid/wready out/out/out/in 32/4/1/1 write data channel
m_axi_bresp/bvalid/bready in/in/out 2/1/1 write response channel
m_axi_araddr/arprot/arvalid/arready out/out/out/in 32/3/1/1 read address channel
m_axi_rdata/rresp/rvalid/rready in/in/in/out 32/2/1/1 read data channel

Behaviour:
- Reset: all sampled on ACLK when ARESETN=0. All valid/ready outputs 0, busy/done/err 0, err_code 0, addr/data 0, state IDLE, counters 0. Reset mid-transaction aborts immediately with no completion.
- awprot=arprot=3'b000; wstrb=4'hF always.
- IDLE: start=1 latches cfg_data into an internal copy, clears err_code, sets idx=0, busy=1, goes to WR.
- WR: awvalid and wvalid are asserted together in the same cycle. awaddr=BASE_ADDR+4*idx, wdata=word idx. Each valid drops independently after its own handshake (valid&ready); AW and W handshakes may complete in either order or in the same cycle. After both complete, go to WRESP.
- WRESP: bready=1. On bvalid: if bresp!=OKAY, set err_code=01 and go to ERR. Otherwise, if idx<NUM_CFG-1, increment idx and return to WR; else go to CTRL.
- CTRL: same handshake as WR, with address BASE_ADDR+CTRL_OFF and data 32'h1, then wait for the response as in WRESP. Error sets err_code=01 and goes to ERR; OKAY clears poll_cnt and goes to GAP.
- GAP: wait POLL_GAP cycles, then go to RADDR.
- RADDR: arvalid=1, araddr=BASE_ADDR+STAT_OFF, held until arready. Then go to RDATA.
- RDATA: rready=1. On rvalid:
  - rresp!=OKAY: err_code=10, go to ERR.
  - rdata[0]=1: go to DONE.
  - otherwise poll_cnt+1; if poll_cnt reaches POLL_MAX, err_code=11 and go to ERR; else go to GAP.
- DONE: done=1 for one cycle, busy=0, go to IDLE. ERR: err=1 for one cycle, busy=0, go to IDLE.
- start while busy=1 is ignored. start in the same cycle as the done/err pulse is ignored; it is accepted the following cycle.
- Outputs must not change while valid=1 and ready=0 (AXI stability).
- Valid never depends combinationally on ready.
- At most one outstanding transaction at any time.
- cfg_data changes after start do not affect the running sequence.

Test Plan:
- NUM_CFG=4, cfg_data={0xbeef0011,0xdead0011,0xabcd0001,0x0101FFFF}, slave always ready, done on first poll -> writes to 0x4000_0000/04/08/0C with matching data, then 0x4000_0020=0x1; one read of 0x4000_0024; done pulse; busy high throughout.
- Slave asserts wready 3 cycles before awready, then the reverse on the next word -> each word is written exactly once with the correct addr/data; valids drop only after their own handshake.
- bresp=SLVERR on the third config write -> no further AW; err pulse, err_code=01, busy=0.
- Status returns 0 for five polls then 1 -> exactly 6 reads spaced >=16 idle cycles apart, then done.
- Status never done, POLL_MAX=8 -> exactly 8 reads, err_code=11. rresp=DECERR on the first read -> err_code=10.
- ARESETN low for one cycle while awvalid is stalled -> next cycle all valids 0, busy 0; a following start runs a clean full sequence.
